writeback_port: RTL

- Single owner of the register file write port (WriteEn / rd1Adr / Rd1).
- Merges two result sources into that one port:
  - the in-order pipeline writeback, which is never stalled;
  - a multi-cycle unit (divider/multiplier) through a valid/ready handshake and a small FIFO.
- Publishes a pending-destination mask so the hazard unit can stall readers of registers that still have a queued write.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/wb_fifo.sv | 108 ++++++++++
 rtl/writeback_port.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback port.
// Data width follows `BIT_COUNT (defaults to 32 when not supplied by the build).
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package wb_pkg;

    // Datapath width of one register-file write.
    localparam int WB_DATA_W   = `BIT_COUNT;

    // Destination field is sized for the largest register file this port supports;
    // each instance only ever stores addresses below its own REGISTER_COUNT.
    localparam int WB_RD_MAX_W = 8;
    localparam int WB_REG_MAX  = 256;

    // One queued multi-cycle result. valid=0 marks a squashed (or empty) slot.
    typedef struct packed {
        logic                   valid;
        logic [WB_RD_MAX_W-1:0] rd;
        logic [WB_DATA_W-1:0]   data;
    } wb_entry_t;

    // One-hot decode of a destination register address.
    function automatic logic [WB_REG_MAX-1:0] onehot_rd(input logic [WB_RD_MAX_W-1:0] rd);
        logic [WB_REG_MAX-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular queue of multi-cycle results awaiting the register-file write port.
// Supports squash-by-destination so a younger pipeline write invalidates older
// queued writes to the same register, and publishes the pending-destination mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int REGISTER_COUNT = 32,
    parameter int FIFO_DEPTH     = 4,
    localparam int PW            = $clog2(FIFO_DEPTH),
    localparam int CW            = PW + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  wb_entry_t                 push_entry_i,
    input  logic                      pop_i,
    input  logic                      squash_i,
    input  logic [WB_RD_MAX_W-1:0]    squash_rd_i,
    output wb_entry_t                 head_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [CW-1:0]             count_o,
    output logic [REGISTER_COUNT-1:0] pending_mask_o
);

    wb_entry_t        mem_q [FIFO_DEPTH];
    wb_entry_t        mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [WB_REG_MAX-1:0] mask_s;

    assign empty_o   = (count_q == CW'(0));
    assign full_o    = (count_q == CW'(FIFO_DEPTH));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Next-state for storage, pointers and occupancy: squash, then pop, then push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (squash_i && mem_q[i].valid && (mem_q[i].rd == squash_rd_i)) begin
                mem_d[i].valid = 1'b0;
            end else begin
                mem_d[i].valid = mem_q[i].valid;
            end
        end
        if (pop_ok_s) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s) begin
            mem_d[wr_ptr_q]       = push_entry_i;
            // A same-cycle younger pipeline write to this register wins.
            mem_d[wr_ptr_q].valid = push_entry_i.valid &&
                                    !(squash_i && (push_entry_i.rd == squash_rd_i));
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset discards every queued result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pending-destination mask: OR of one-hot destinations of valid entries, r0 excluded.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (mem_q[i].valid && (mem_q[i].rd != '0)) begin
                mask_s = mask_s | onehot_rd(mem_q[i].rd);
            end else begin
                mask_s = mask_s;
            end
        end
    end

    assign pending_mask_o = REGISTER_COUNT'(mask_s);

endmodule

// File: rtl/writeback_port.sv
// Sole owner of the register-file write port. Arbitrates the never-stalled
// pipeline writeback against queued multi-cycle results (pipeline first) and
// drives a registered WriteEn/rd1Adr/Rd1.
// Optional build macro WB_MC_BYPASS_EN: an accepted multi-cycle result that
// finds the queue empty and the pipeline silent is written one cycle earlier,
// skipping the queue.
module writeback_port
    import wb_pkg::*;
#(
    parameter int REGISTER_COUNT = 32,
    parameter int FIFO_DEPTH     = 4,
    localparam int AW            = $clog2(REGISTER_COUNT),
    localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipeValid,
    input  logic [AW-1:0]             pipeRdAdr,
    input  logic [WB_DATA_W-1:0]      pipeResult,
    input  logic                      mcValid,
    output logic                      mcReady,
    input  logic [AW-1:0]             mcRdAdr,
    input  logic [WB_DATA_W-1:0]      mcResult,
    output logic                      WriteEn,
    output logic [AW-1:0]             rd1Adr,
    output logic [WB_DATA_W-1:0]      Rd1,
    output logic [REGISTER_COUNT-1:0] pendingMask,
    output logic [CW-1:0]             fifoCount
);

    logic                 pipe_wr_s;
    logic                 mc_keep_s;
    logic                 bypass_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 full_s;
    wb_entry_t            push_entry_s;
    wb_entry_t            head_s;
    logic                 we_q, we_d;
    logic [AW-1:0]        adr_q, adr_d;
    logic [WB_DATA_W-1:0] data_q, data_d;

    // A pipeline result to r0 is not a write and does not block the queue.
    assign pipe_wr_s = pipeValid && (pipeRdAdr != '0);

    // Readiness depends only on occupancy, never on a same-cycle dequeue.
    assign mcReady   = !full_s;

    // Accepted results to r0 are consumed here and never reach the queue.
    assign mc_keep_s = mcValid && mcReady && (mcRdAdr != '0);

`ifdef WB_MC_BYPASS_EN
    assign bypass_s  = mc_keep_s && empty_s && !pipe_wr_s;
`else
    assign bypass_s  = 1'b0;
`endif

    assign push_s    = mc_keep_s && !bypass_s;
    assign pop_s     = !pipe_wr_s && !empty_s;

    assign push_entry_s.valid = 1'b1;
    assign push_entry_s.rd    = WB_RD_MAX_W'(mcRdAdr);
    assign push_entry_s.data  = mcResult;

    wb_fifo #(
        .REGISTER_COUNT (REGISTER_COUNT),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_i          (clk),
        .rst_i          (reset),
        .push_i         (push_s),
        .push_entry_i   (push_entry_s),
        .pop_i          (pop_s),
        .squash_i       (pipe_wr_s),
        .squash_rd_i    (WB_RD_MAX_W'(pipeRdAdr)),
        .head_o         (head_s),
        .empty_o        (empty_s),
        .full_o         (full_s),
        .count_o        (fifoCount),
        .pending_mask_o (pendingMask)
    );

    // Write-port source selection: pipeline, else queue head, else bypass, else idle.
    always_comb begin
        we_d   = 1'b0;
        adr_d  = adr_q;
        data_d = data_q;
        if (pipe_wr_s) begin
            we_d   = 1'b1;
            adr_d  = pipeRdAdr;
            data_d = pipeResult;
        end else if (pop_s) begin
            // A squashed head is popped but must not write.
            we_d   = head_s.valid;
            adr_d  = AW'(head_s.rd);
            data_d = head_s.data;
        end else if (bypass_s) begin
            we_d   = 1'b1;
            adr_d  = mcRdAdr;
            data_d = mcResult;
        end else begin
            we_d   = 1'b0;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            adr_q  <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            adr_q  <= adr_d;
            data_q <= data_d;
        end
    end

    assign WriteEn = we_q;
    assign rd1Adr  = adr_q;
    assign Rd1     = data_q;

endmodule
